// File: rtl/coef_ctrl_pkg.sv
// Shared constants and state encoding for the coefficient update sequencer.
// The 6-bit FSM_Top address bus fixes the set length at 64 words.
package coef_ctrl_pkg;

  localparam int NUM_COEF        = 64;
  localparam int ADDR_W          = 6;
  localparam int DATA_W          = 16;
  localparam int DEF_TIMEOUT_CYC = 255;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SYNC    = 3'd1,
    ST_ARM     = 3'd2,
    ST_WRITE   = 3'd3,
    ST_DRAIN   = 3'd4,
    ST_RELEASE = 3'd5,
    ST_ABORT   = 3'd6
  } state_t;

endpackage

// File: rtl/coef_update_ctrl_if.sv
// Coefficient stream (valid/ready) plus the FSM_Top coefficient RAM access bus.
// The sequencer is the master: it consumes the stream and drives the bus.
interface coef_update_ctrl_if;
  import coef_ctrl_pkg::*;

  logic              iCoefValid;
  logic [DATA_W-1:0] iCoefData;
  logic              oCoefReady;
  logic              oUpdateFlag;
  logic [ADDR_W-1:0] oAddr;
  logic              oCsn;
  logic              oWrn;
  logic [DATA_W-1:0] oWrDt;

  modport master (
    input  iCoefValid, iCoefData,
    output oCoefReady, oUpdateFlag, oAddr, oCsn, oWrn, oWrDt
  );

  modport slave (
    output iCoefValid, iCoefData,
    input  oCoefReady, oUpdateFlag, oAddr, oCsn, oWrn, oWrDt
  );

endinterface

// File: rtl/coef_beat_timer.sv
// Saturating idle-cycle counter; timeout is high once TIMEOUT_CYC idle cycles
// have been counted since the last clear.
module coef_beat_timer #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic srst,
  input  logic clr,
  input  logic en,
  output logic timeout
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (en && (cnt_reg != CNT_MAX)) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign timeout = (cnt_reg == CNT_MAX);

endmodule

// File: rtl/coef_update_ctrl.sv
// Loads a full coefficient set into the FIR coefficient banks through the FSM_Top
// access bus, aligned to a 600 kHz sample strobe, with stall timeout and abort.
module coef_update_ctrl
  import coef_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                      iClk_12M,
  input  logic                      iRst,
  input  logic                      iEnSample600k,
  input  logic                      iStart,
  input  logic                      iErrClr,
  coef_update_ctrl_if.master        bus,
  output logic                      oBusy,
  output logic                      oDone,
  output logic                      oErr
);

  // One extra count bit so the counter can reach NUM_COEF without wrapping.
  localparam int CNT_W = $clog2(NUM_COEF) + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_COEF - 1);
  localparam logic [CNT_W-1:0] SET_LEN  = CNT_W'(NUM_COEF);

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  count_reg, count_next;
  logic              ready_reg, ready_next;
  logic              flag_reg,  flag_next;
  logic              csn_reg,   csn_next;
  logic              wrn_reg,   wrn_next;
  logic [ADDR_W-1:0] addr_reg,  addr_next;
  logic [DATA_W-1:0] wrdt_reg,  wrdt_next;
  logic              busy_reg,  busy_next;
  logic              done_reg,  done_next;
  logic              err_reg,   err_next;

  logic beat;
  logic last_beat;
  logic issue_write;
  logic timer_clr;
  logic timer_en;
  logic timeout;

  assign beat        = (state_reg == ST_WRITE) && bus.iCoefValid && ready_reg;
  assign last_beat   = beat && (count_reg == LAST_IDX);
  assign issue_write = beat && (count_reg < SET_LEN);

  // Leaving WRITE clears the timer, so every entry to WRITE starts from zero.
  assign timer_clr = beat || (state_reg != ST_WRITE);
  assign timer_en  = (state_reg == ST_WRITE);

  coef_beat_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_beat_timer (
    .clk     (iClk_12M),
    .srst    (iRst),
    .clr     (timer_clr),
    .en      (timer_en),
    .timeout (timeout)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:    if (iStart) state_next = ST_SYNC;
      ST_SYNC:    if (iEnSample600k) state_next = ST_ARM;
      ST_ARM:     state_next = ST_WRITE;
      ST_WRITE: begin
        if (last_beat) begin
          state_next = ST_DRAIN;
        end else if (!beat && timeout) begin
          state_next = ST_ABORT;
        end
      end
      ST_DRAIN:   state_next = ST_RELEASE;
      ST_RELEASE: state_next = ST_IDLE;
      ST_ABORT:   state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they appear registered in the
  // same cycle the FSM enters the corresponding state.
  always_comb begin
    count_next = count_reg;
    ready_next = (state_next == ST_WRITE);
    flag_next  = (state_next == ST_ARM)   || (state_next == ST_WRITE) ||
                 (state_next == ST_DRAIN) || (state_next == ST_RELEASE) ||
                 (state_next == ST_ABORT);
    csn_next   = 1'b1;
    wrn_next   = 1'b1;
    addr_next  = addr_reg;
    wrdt_next  = wrdt_reg;
    busy_next  = (state_next != ST_IDLE);
    done_next  = (state_reg == ST_RELEASE);
    err_next   = err_reg;

    if ((state_next == ST_SYNC) || (state_next == ST_ABORT)) begin
      count_next = '0;
    end else if (issue_write) begin
      count_next = count_reg + 1'b1;
    end

    if (issue_write) begin
      csn_next  = 1'b0;
      wrn_next  = 1'b0;
      addr_next = count_reg[ADDR_W-1:0];
      wrdt_next = bus.iCoefData;
    end

    // A fresh abort outranks a simultaneous clear request.
    if (state_next == ST_ABORT) begin
      err_next = 1'b1;
    end else if (iErrClr) begin
      err_next = 1'b0;
    end
  end

  always_ff @(posedge iClk_12M) begin
    if (iRst) begin
      state_reg <= ST_IDLE;
      count_reg <= '0;
      ready_reg <= 1'b0;
      flag_reg  <= 1'b0;
      csn_reg   <= 1'b1;
      wrn_reg   <= 1'b1;
      addr_reg  <= '0;
      wrdt_reg  <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      ready_reg <= ready_next;
      flag_reg  <= flag_next;
      csn_reg   <= csn_next;
      wrn_reg   <= wrn_next;
      addr_reg  <= addr_next;
      wrdt_reg  <= wrdt_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
      err_reg   <= err_next;
    end
  end

  assign bus.oCoefReady  = ready_reg;
  assign bus.oUpdateFlag = flag_reg;
  assign bus.oCsn        = csn_reg;
  assign bus.oWrn        = wrn_reg;
  assign bus.oAddr       = addr_reg;
  assign bus.oWrDt       = wrdt_reg;
  assign oBusy           = busy_reg;
  assign oDone           = done_reg;
  assign oErr            = err_reg;

endmodule

// File: tb/tb_coef_update_ctrl.sv
// Randomized bench for coef_update_ctrl: expected writes are the accepted stream
// words in arrival order at addresses 0..63, checked against the observed bus.
`timescale 1ns/1ps
module tb_coef_update_ctrl;
  import coef_ctrl_pkg::*;

  localparam int TMO = 255;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, en600k, start, err_clr;
  logic busy, done, err;

  coef_update_ctrl_if bus ();

  coef_update_ctrl #(
    .TIMEOUT_CYC (TMO)
  ) dut (
    .iClk_12M      (clk),
    .iRst          (rst),
    .iEnSample600k (en600k),
    .iStart        (start),
    .iErrClr       (err_clr),
    .bus           (bus),
    .oBusy         (busy),
    .oDone         (done),
    .oErr          (err)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Bus monitor: records every write and checks the release/done ordering.
  typedef struct {
    int addr;
    int data;
    int cyc;
  } wr_t;

  wr_t  wr_q[$];
  int   done_cnt = 0;
  int   cyc = 0;
  logic prev_flag = 1'b0;
  logic prev_csn  = 1'b1;
  logic prev2_csn = 1'b1;

  always @(posedge clk) begin
    wr_t w;
    #2;
    cyc++;
    if (bus.oCsn === 1'b0) begin
      check_val("wr_wrn", bus.oWrn, 0);
      check_val("wr_flag", bus.oUpdateFlag, 1);
      w.addr = int'(bus.oAddr);
      w.data = int'(bus.oWrDt);
      w.cyc  = cyc;
      wr_q.push_back(w);
    end
    if (done === 1'b1) begin
      done_cnt++;
      check_val("done_flag_low", bus.oUpdateFlag, 0);
      check_val("release_flag", prev_flag, 1);
      check_val("release_csn", prev_csn, 1);
      check_val("drain_write", prev2_csn, 0);
    end
    prev2_csn = prev_csn;
    prev_csn  = bus.oCsn;
    prev_flag = bus.oUpdateFlag;
  end

  // pattern: 0 back-to-back data 0x1000+i, 1 valid toggling, 2 random valid/data.
  task automatic run_load(input int pattern, input int stall_after, input int rst_after,
                          input bit extra_start, input bit same_strobe);
    int   exp_q[$];
    int   sent;
    int   cycles;
    int   n;
    int   late;
    int   d;
    logic v;

    sent   = 0;
    cycles = 0;
    late   = 0;
    wr_q.delete();
    done_cnt = 0;

    start  = 1'b1;
    en600k = same_strobe;
    tick;
    start  = 1'b0;
    en600k = 1'b0;
    check_val("sync_busy", busy, 1);
    check_val("sync_flag", bus.oUpdateFlag, 0);
    repeat ($urandom_range(1, 8)) tick;
    check_val("sync_wait_flag", bus.oUpdateFlag, 0);

    en600k = 1'b1;
    tick;
    en600k = 1'b0;
    check_val("arm_flag", bus.oUpdateFlag, 1);
    check_val("arm_csn", bus.oCsn, 1);
    check_val("arm_ready", bus.oCoefReady, 0);

    while (sent < NUM_COEF && cycles < 3000) begin
      if (stall_after != 0 && sent == stall_after) break;
      if (rst_after != 0 && sent == rst_after) break;
      case (pattern)
        0:       v = 1'b1;
        1:       v = (cycles % 2 == 0);
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      d = (pattern == 0) ? (32'h1000 + sent) : int'($urandom_range(0, 65535));
      bus.iCoefValid = v;
      bus.iCoefData  = d[15:0];
      if (extra_start && sent == 20) start = 1'b1;
      if (v && bus.oCoefReady === 1'b1) begin
        exp_q.push_back(d);
        sent++;
      end
      tick;
      start = 1'b0;
      cycles++;
    end
    bus.iCoefValid = 1'b0;

    if (stall_after != 0) begin
      n = 0;
      while (n < 400) begin
        n++;
        if (n == TMO + 1) err_clr = 1'b1;
        tick;
        err_clr = 1'b0;
        if (err === 1'b1) break;
      end
      check_val("abort_latency", n, TMO + 1);
      check_val("abort_err", err, 1);
      check_val("abort_csn", bus.oCsn, 1);
      check_val("abort_ready", bus.oCoefReady, 0);
      tick;
      check_val("abort_exit_flag", bus.oUpdateFlag, 0);
      check_val("abort_exit_busy", busy, 0);
      repeat (5) tick;
      check_val("err_sticky", err, 1);
      check_val("abort_no_done", done_cnt, 0);
      check_val("abort_wr_cnt", wr_q.size(), stall_after);
      err_clr = 1'b1;
      tick;
      err_clr = 1'b0;
      check_val("err_clear", err, 0);
      $display("load pattern=%0d stalled after %0d beats, aborted after %0d idle cycles", pattern, sent, n);
      return;
    end

    if (rst_after != 0) begin
      rst = 1'b1;
      tick;
      check_val("rst_csn", bus.oCsn, 1);
      check_val("rst_wrn", bus.oWrn, 1);
      check_val("rst_flag", bus.oUpdateFlag, 0);
      check_val("rst_busy", busy, 0);
      check_val("rst_ready", bus.oCoefReady, 0);
      rst = 1'b0;
      tick;
      check_val("rst_wr_cnt", wr_q.size(), rst_after);
      check_val("rst_no_done", done_cnt, 0);
      $display("load pattern=%0d reset after %0d beats", pattern, sent);
      return;
    end

    // Keep offering words after the set is complete; none may be accepted.
    bus.iCoefValid = 1'b1;
    bus.iCoefData  = 16'hDEAD;
    for (int i = 0; i < 6; i++) begin
      if (bus.oCoefReady === 1'b1) late++;
      tick;
    end
    bus.iCoefValid = 1'b0;
    n = 0;
    while (done_cnt == 0 && n < 50) begin
      tick;
      n++;
    end
    repeat (3) tick;

    check_val("beats_sent", sent, NUM_COEF);
    check_val("no_65th_beat", late, 0);
    check_val("done_once", done_cnt, 1);
    check_val("end_busy", busy, 0);
    check_val("end_flag", bus.oUpdateFlag, 0);
    check_val("wr_count", wr_q.size(), exp_q.size());
    for (int i = 0; i < wr_q.size() && i < exp_q.size(); i++) begin
      check_val($sformatf("wr_addr[%0d]", i), wr_q[i].addr, i);
      check_val($sformatf("wr_data[%0d]", i), wr_q[i].data, exp_q[i]);
    end
    if (pattern == 0 && wr_q.size() == NUM_COEF) begin
      check_val("wr_consecutive", wr_q[NUM_COEF-1].cyc - wr_q[0].cyc, NUM_COEF - 1);
    end
    $display("load pattern=%0d beats=%0d writes=%0d done=%0d cycles=%0d", pattern, sent, wr_q.size(), done_cnt, cycles);
  endtask

  initial begin
    rst            = 1'b1;
    start          = 1'b0;
    en600k         = 1'b0;
    err_clr        = 1'b0;
    bus.iCoefValid = 1'b0;
    bus.iCoefData  = '0;
    repeat (3) tick;
    check_val("reset_flag", bus.oUpdateFlag, 0);
    check_val("reset_csn", bus.oCsn, 1);
    check_val("reset_wrn", bus.oWrn, 1);
    check_val("reset_addr", bus.oAddr, 0);
    check_val("reset_wrdt", bus.oWrDt, 0);
    check_val("reset_ready", bus.oCoefReady, 0);
    check_val("reset_busy", busy, 0);
    check_val("reset_done", done, 0);
    check_val("reset_err", err, 0);

    rst            = 1'b0;
    bus.iCoefValid = 1'b1;
    en600k         = 1'b1;
    repeat (3) tick;
    check_val("idle_ready", bus.oCoefReady, 0);
    check_val("idle_busy", busy, 0);
    bus.iCoefValid = 1'b0;
    en600k         = 1'b0;
    tick;

    run_load(0, 0, 0, 1'b0, 1'b0);
    run_load(1, 0, 0, 1'b0, 1'b1);
    run_load(0, 10, 0, 1'b0, 1'b0);
    run_load(2, 0, 0, 1'b0, 1'b0);
    run_load(0, 0, 30, 1'b0, 1'b0);
    run_load(0, 0, 0, 1'b0, 1'b0);
    run_load(2, 0, 0, 1'b1, 1'b0);
    run_load(2, 0, 0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
